// File: rtl/ifetch_queue_if.sv
// Fetch engine bus: instruction-memory request/response channel plus the
// core-facing instruction queue head.
//
// Handshake semantics: a request transfers on a rising edge where
// mem_req_valid && mem_req_ready. While valid is high and ready is low, the
// request (mem_req_addr) is held stable. Responses (mem_rsp_valid) have no
// ready: they return in request order and must always be taken. The core pops
// the queue head on an edge where ins_valid && ins_ready.
interface ifetch_queue_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ins_ready;
  logic        ins_valid;
  logic [31:0] ins_out;
  logic [31:0] pc_out;

  // Fetch engine side
  modport master (
    output mem_req_valid, mem_req_addr, ins_valid, ins_out, pc_out,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, redirect, redirect_pc,
    input  ins_ready
  );

  // Memory / core side
  modport slave (
    input  mem_req_valid, mem_req_addr, ins_valid, ins_out, pc_out,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, redirect, redirect_pc,
    output ins_ready
  );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: issues word fetches to a variable-latency
// instruction memory, queues {pc, instruction} pairs in order for the core,
// and on a redirect flushes the queue and drops responses still in flight.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   rst,
  ifetch_queue_if.master         bus,
  output logic [$clog2(DEPTH):0] dbg_count,
  output logic [$clog2(DEPTH):0] dbg_outstanding,
  output logic [$clog2(DEPTH):0] dbg_discard
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [CW-1:0] count, outstanding, discard, outstanding_next;
  logic [CW:0]   credit_used;
  logic [PW-1:0] head, tail;
  logic [31:0]   fetch_pc, rsp_pc;
  logic [31:0]   pc_mem  [DEPTH];
  logic [31:0]   ins_mem [DEPTH];
  logic          run;
  logic          req_fire, push, pop;

  // Credit-based issue, queue push/pop decisions and head outputs.
  // 'run' keeps requests off until the first edge after reset release.
  always_comb begin
    credit_used       = {1'b0, count} + {1'b0, outstanding};
    bus.mem_req_valid = run && !bus.redirect && (credit_used < (CW+1)'(DEPTH));
    bus.mem_req_addr  = fetch_pc;
    req_fire          = bus.mem_req_valid && bus.mem_req_ready;
    push              = bus.mem_rsp_valid && (discard == '0) && !bus.redirect;
    bus.ins_valid     = (count != '0);
    pop               = bus.ins_valid && bus.ins_ready && !bus.redirect;
    outstanding_next  = outstanding + CW'(req_fire) - CW'(bus.mem_rsp_valid);
    bus.ins_out       = bus.ins_valid ? ins_mem[head] : NOP;
    bus.pc_out        = bus.ins_valid ? pc_mem[head]  : 32'h0;
  end

  // Control state: pointers, counters and the two pc trackers; redirect wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run         <= 1'b0;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      head        <= '0;
      tail        <= '0;
    end else begin
      run         <= 1'b1;
      outstanding <= outstanding_next;
      if (req_fire) fetch_pc <= fetch_pc + 32'd4;
      if (bus.redirect) begin
        // Everything still in flight after this cycle belongs to the old path.
        count    <= '0;
        head     <= '0;
        tail     <= '0;
        fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
        rsp_pc   <= {bus.redirect_pc[31:2], 2'b00};
        discard  <= outstanding_next;
      end else begin
        if (bus.mem_rsp_valid && (discard != '0)) discard <= discard - CW'(1);
        if (push) begin
          tail   <= tail + PW'(1);
          rsp_pc <= rsp_pc + 32'd4;
        end
        if (pop) head <= head + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Queue storage; contents are only observed through count, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail]  <= rsp_pc;
      ins_mem[tail] <= bus.mem_rsp_data;
    end
  end

  assign dbg_count       = count;
  assign dbg_outstanding = outstanding;
  assign dbg_discard     = discard;

  a_credit: assert property (@(posedge clk) disable iff (!rst)
    credit_used <= (CW+1)'(DEPTH));
  a_discard: assert property (@(posedge clk) disable iff (!rst)
    discard <= outstanding);
  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst)
    bus.mem_rsp_valid |-> (outstanding != '0));
endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed scenarios followed by random traffic,
// checked cycle by cycle against a queue-level model of the fetch path.
module tb_ifetch_queue;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } fl_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0] dbg_count, dbg_outstanding, dbg_discard;

  ifetch_queue_if bus ();

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0), .NOP(NOP)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .dbg_count       (dbg_count),
    .dbg_outstanding (dbg_outstanding),
    .dbg_discard     (dbg_discard)
  );

  // Clock
  always #5 clk = ~clk;

  // Model state: delivered-entry scoreboard and in-flight request list
  logic [63:0] exp_q[$];
  fl_t         fl_q[$];
  logic [31:0] m_fetch_pc;
  bit          m_run;
  int          cyc, last_due, lat_min, lat_max;
  int          n_cmp = 0;
  int          n_fail = 0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0013_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    fl_q.delete();
    m_fetch_pc = 32'h0;
    m_run      = 1'b0;
    last_due   = 0;
  endtask

  task automatic idle_inputs();
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = 32'h0;
    bus.redirect      = 1'b0;
    bus.redirect_pc   = 32'h0;
    bus.ins_ready     = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ins_valid"}, 32'(bus.ins_valid), 32'h0);
    check({tag, "_ins_out"}, bus.ins_out, NOP);
    check({tag, "_pc_out"}, bus.pc_out, 32'h0);
    check({tag, "_req_valid"}, 32'(bus.mem_req_valid), 32'h0);
    check({tag, "_req_addr"}, bus.mem_req_addr, 32'h0);
    check({tag, "_count"}, 32'(dbg_count), 32'h0);
  endtask

  // Reset asserted away from any edge; outputs must react without a clock.
  task automatic apply_reset(input string tag);
    #2;
    rst = 1'b0;
    idle_inputs();
    #1;
    check_reset_outputs(tag);
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs({tag, "_held"});
    rst = 1'b1;
    model_reset();
  endtask

  // One clock cycle: check settled outputs, drive inputs, advance the model.
  task automatic step(input bit rdy, input bit irdy, input bit redir, input logic [31:0] rpc);
    logic [63:0] head_e;
    logic [31:0] rdata;
    bit          exp_rv, rsp, acc;
    fl_t         f;
    int          stale_n, due;
    head_e = (exp_q.size() != 0) ? exp_q[0] : {32'h0, NOP};
    stale_n = 0;
    foreach (fl_q[i]) if (fl_q[i].stale) stale_n++;
    check("ins_valid", 32'(bus.ins_valid), 32'(exp_q.size() != 0));
    check("pc_out", bus.pc_out, head_e[63:32]);
    check("ins_out", bus.ins_out, head_e[31:0]);
    check("req_addr", bus.mem_req_addr, m_fetch_pc);
    check("count", 32'(dbg_count), 32'(exp_q.size()));
    check("outstanding", 32'(dbg_outstanding), 32'(fl_q.size()));
    check("discard", 32'(dbg_discard), 32'(stale_n));

    rsp   = (fl_q.size() != 0) && (fl_q[0].due <= cyc);
    rdata = rsp ? mem_data(fl_q[0].addr) : 32'h0;
    bus.mem_req_ready = rdy;
    bus.ins_ready     = irdy;
    bus.redirect      = redir;
    bus.redirect_pc   = rpc;
    bus.mem_rsp_valid = rsp;
    bus.mem_rsp_data  = rdata;
    #1;
    exp_rv = m_run && !redir && (exp_q.size() + fl_q.size() < DEPTH);
    check("req_valid", 32'(bus.mem_req_valid), 32'(exp_rv));
    acc = exp_rv && rdy;

    if (!redir && irdy && exp_q.size() != 0) void'(exp_q.pop_front());
    if (rsp) begin
      f = fl_q.pop_front();
      if (!f.stale && !redir) exp_q.push_back({f.addr, rdata});
    end
    if (acc) begin
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      fl_q.push_back('{addr: m_fetch_pc, due: due, stale: 1'b0});
      m_fetch_pc = m_fetch_pc + 32'd4;
    end
    if (redir) begin
      exp_q.delete();
      foreach (fl_q[i]) fl_q[i].stale = 1'b1;
      m_fetch_pc = {rpc[31:2], 2'b00};
    end
    m_run = 1'b1;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    model_reset();
    cyc = 0;
    lat_min = 1;
    lat_max = 1;

    // Power-on reset
    @(negedge clk);
    apply_reset("por");

    // Streaming fetch with 1-cycle memory
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Backpressure and fill from reset
    apply_reset("fill_rst");
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    check("fill_count", 32'(dbg_count), 32'd4);
    check("fill_addr", bus.mem_req_addr, 32'h10);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("refill_addr", bus.mem_req_addr, 32'h10);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect with two in-flight responses, 3-cycle memory
    apply_reset("redir_rst");
    lat_min = 3;
    lat_max = 3;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h100);
    check("redir_discard", 32'(dbg_discard), 32'd2);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect coincident with a response and a pop
    lat_min = 1;
    lat_max = 1;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h402);
    check("coinc_empty", 32'(bus.ins_valid), 32'h0);
    check("coinc_addr", bus.mem_req_addr, 32'h400);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Back-to-back redirects before the first target returns
    lat_min = 3;
    lat_max = 3;
    step(1'b1, 1'b1, 1'b1, 32'h200);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h300);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    check("b2b_discard", 32'(dbg_discard), 32'h0);

    // Async reset while the queue is full, then restart
    lat_min = 1;
    lat_max = 1;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    check("full_count", 32'(dbg_count), 32'd4);
    apply_reset("async");
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Random traffic with variable memory latency
    lat_min = 1;
    lat_max = 4;
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(3, 0) != 0, $urandom_range(1, 0) != 0,
           $urandom_range(11, 0) == 0, $urandom());
    end
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
    check("drain_outstanding", 32'(dbg_outstanding), 32'h0);

    // Report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the pipelined RISC-V core's IF/ID register.
- Replaces the core's single-cycle instruction memory lookup with a request/response fetch engine that works with variable-latency instruction memory.
- Keeps a small in-order queue of {pc, instruction} pairs for the core to consume.
- Handles redirects from branches, jal and jalr by flushing the queue and squashing in-flight responses.

Parameters:
- DEPTH, 4, queue entries and maximum outstanding requests; power of two, >= 2.
- RESET_PC, 32'h00000000, first fetch address after reset.
- NOP, 32'h00000013, value driven on ins_out when the queue is empty.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_req_valid  out  1  fetch request valid.
- mem_req_ready  in  1  memory accepts the request this cycle.
- mem_req_addr  out  32  fetch address, word aligned.
- mem_rsp_valid  in  1  response valid. Responses return in request order, at least 1 cycle after acceptance, and cannot be back-pressured.
- mem_rsp_data  in  32  fetched instruction.
- redirect  in  1  pcsrc from the EX/MEM stage; flush and restart.
- redirect_pc  in  32  new fetch address; sampled only when redirect=1.
- ins_ready  in  1  core consumes the head entry (driven by enable_if).
- ins_valid  out  1  queue non-empty.
- ins_out  out  32  head instruction, or NOP when empty.
- pc_out  out  32  head pc, or 0 when empty.

Behaviour:
- Reset (rst=0, asynchronous), values held until the first edge after deassertion:
  - fetch_pc=RESET_PC, rsp_pc=RESET_PC.
  - count=0, outstanding=0, discard=0.
  - Outputs: ins_valid=0, ins_out=NOP, pc_out=0, mem_req_valid=0, mem_req_addr=RESET_PC.
  - Instruction memory shares this reset, so no pre-reset responses arrive afterwards.
- Counters, each $clog2(DEPTH)+1 bits:
  - count: valid queue entries.
  - outstanding: accepted requests without a response, including those being discarded.
  - discard: responses still to be dropped.
- Request issue:
  - mem_req_valid = !redirect && (count + outstanding < DEPTH); this credit rule guarantees the queue never overflows.
  - mem_req_addr = fetch_pc.
  - On accept (valid && ready): fetch_pc <= fetch_pc+4 and outstanding increments.
  - mem_req_addr is held stable while valid && !ready.
- Response:
  - Every mem_rsp_valid decrements outstanding.
  - If discard != 0: the response is dropped and discard decrements.
  - Otherwise: push {rsp_pc, mem_rsp_data} at the tail and rsp_pc <= rsp_pc+4.
- Consume:
  - pop when ins_valid && ins_ready && !redirect.
  - ins_out and pc_out come combinationally from the registered head entry.
- Simultaneous push and pop:
  - count is unchanged.
  - When count==1, the popped entry is the old head and the pushed entry becomes the head next cycle.
- Redirect (highest priority in its cycle):
  - queue cleared (count<=0), no pop, no request issued.
  - fetch_pc<=redirect_pc, rsp_pc<=redirect_pc.
  - discard <= outstanding_next, i.e. outstanding after this cycle's accept/response bookkeeping. A response arriving in the redirect cycle is itself dropped and not counted.
  - A redirect while discard!=0 adds the new in-flight requests to discard, so no stale instruction is ever delivered.
- Latency:
  - A response accepted in cycle R is visible as ins_valid in cycle R+1.
  - With redirect in cycle N, ready=1 and 1-cycle memory: request issued in N+1, response in N+2, ins_valid in N+3.
- Wrap-around: head and tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; fetch_pc wraps modulo 2^32.
- Full: count==DEPTH → ins_valid=1 and mem_req_valid=0.
- Empty with a pop attempt: ignored, no underflow.
- redirect_pc[1:0] is ignored (forced to 0).
- Assertions (verification only):
  - count+outstanding <= DEPTH.
  - discard <= outstanding.
  - No mem_rsp_valid while outstanding==0.

Test Plan:
1. Streaming fetch:
   - Stimulus: reset, then ready=1, 1-cycle memory returning addr-based data, ins_ready=1.
   - Required: pc_out sequence 0,4,8,... in consecutive cycles after the first ins_valid (cycle 3 after reset release); ins_out matches memory.
2. Backpressure and fill:
   - Stimulus: ins_ready=0 with DEPTH=4.
   - Required: exactly 4 requests (0x0..0xC) issued, count=4, mem_req_valid=0. After ins_ready=1 for one cycle, a request for 0x10 issues the next cycle.
3. Redirect with in-flight responses:
   - Stimulus: 3-cycle memory, 2 requests outstanding, redirect=1 with redirect_pc=0x100.
   - Required: both stale responses dropped; the first delivered entry is pc_out=0x100 with its data; ins_valid=0 in the meantime.
4. Redirect coincident with a response and a pop:
   - Required: the response is dropped, no pop occurs, the queue is empty next cycle, and the next fetch address is redirect_pc.
5. Back-to-back redirects:
   - Stimulus: redirect to 0x200, then to 0x300 two cycles later, before 0x200 returns.
   - Required: only pc 0x300 onward is delivered; discard returns to 0.
6. Async reset mid-operation:
   - Stimulus: rst low mid-cycle while the queue is full.
   - Required: outputs go to reset values immediately, without a clock; after release, fetch restarts at RESET_PC.
